// File: rtl/conv_out_framer.sv
// conv_out_framer: tags the convolution core's output pixels with frame
// position (sof/eol/eof), buffers them in a first-word-fall-through FIFO and
// presents them on a ready/valid interface. A sticky overflow flag records
// dropped pixels, and frame_done pulses once the eof pixel leaves the buffer.
module conv_out_framer #(
    parameter int PIXEL_BITS = 8,
    parameter int OUT_W      = 126,
    parameter int OUT_H      = 126,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PIXEL_BITS-1:0] in_pixel,
    input  logic                  in_valid,
    output logic [PIXEL_BITS-1:0] out_pixel,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_sof,
    output logic                  out_eol,
    output logic                  out_eof,
    output logic                  overflow,
    output logic                  frame_done,
    output logic                  busy
);

    localparam int CW = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int RW = (OUT_H > 1) ? $clog2(OUT_H) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int WW = PIXEL_BITS + 3;

    localparam logic [CW-1:0] COL_LAST = CW'(OUT_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(OUT_H - 1);

    // Word layout inside the FIFO: {sof, eol, eof, pixel}
    localparam int EOF_BIT = PIXEL_BITS;
    localparam int EOL_BIT = PIXEL_BITS + 1;
    localparam int SOF_BIT = PIXEL_BITS + 2;

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t           r_state;
    state_t           w_nextState;

    logic [CW-1:0]    r_col;
    logic [RW-1:0]    r_row;
    logic             w_colLast;
    logic             w_rowLast;
    logic             w_sof;
    logic             w_eol;
    logic             w_eof;

    logic [WW-1:0]    r_mem [FIFO_DEPTH];
    logic [AW:0]      r_wrPtr;
    logic [AW:0]      r_rdPtr;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic [WW-1:0]    w_head;

    logic             r_overflow;
    logic             r_frameDone;

    // Frame position tags derived from the counters for the pixel arriving now
    always_comb begin
        w_colLast = (r_col == COL_LAST);
        w_rowLast = (r_row == ROW_LAST);
        w_sof     = (r_col == '0) && (r_row == '0);
        w_eol     = w_colLast;
        w_eof     = w_colLast && w_rowLast;
    end

    // Position counters follow every arriving pixel, dropped or not, so the
    // tags never slip relative to the image
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (in_valid) begin
            if (w_colLast) begin
                r_col <= '0;
                if (w_rowLast) begin
                    r_row <= '0;
                end else begin
                    r_row <= r_row + RW'(1);
                end
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

    // Frame state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Enter STREAM on the sof pixel, return to IDLE once the eof pixel arrives
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid && !w_eof) begin
                    w_nextState = STREAM;
                end
            end
            STREAM: begin
                if (in_valid && w_eof) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // FIFO status and handshake; a pop frees the slot a same-cycle push needs
    always_comb begin
        w_empty = (r_wrPtr == r_rdPtr);
        w_full  = (r_wrPtr[AW] != r_rdPtr[AW]) &&
                  (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
        w_pop   = !w_empty && out_ready;
        w_push  = in_valid && (!w_full || w_pop);
        w_drop  = in_valid && w_full && !w_pop;
        w_head  = r_mem[r_rdPtr[AW-1:0]];
    end

    // Storage array; when full with a pop, the write lands in the slot being
    // vacated, which is safe because the head moves on at the same edge
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr[AW-1:0]] <= {w_sof, w_eol, w_eof, in_pixel};
        end
    end

    // Read and write pointers carry an extra wrap bit to separate full from empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + (AW+1)'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + (AW+1)'(1);
            end
        end
    end

    // Sticky overflow flag and the registered end-of-frame pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_frameDone <= 1'b0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            r_frameDone <= w_pop && w_head[EOF_BIT];
        end
    end

    // Head word drives the outputs directly; zeroed when empty so that reset
    // and idle present a clean all-zero bus
    always_comb begin
        out_valid  = !w_empty;
        out_pixel  = w_empty ? '0   : w_head[PIXEL_BITS-1:0];
        out_sof    = w_empty ? 1'b0 : w_head[SOF_BIT];
        out_eol    = w_empty ? 1'b0 : w_head[EOL_BIT];
        out_eof    = w_empty ? 1'b0 : w_head[EOF_BIT];
        overflow   = r_overflow;
        frame_done = r_frameDone;
        busy       = (r_state != IDLE) || !w_empty;
    end

endmodule

// File: tb/tb_conv_out_framer.sv
// tb_conv_out_framer: directed and randomized stimulus for conv_out_framer,
// checked every cycle against a queue-based frame/FIFO reference model.
module tb_conv_out_framer;

    logic       clk;
    logic       rst;
    logic [7:0] in_pixel;
    logic       in_valid;
    logic       out_ready;
    logic       sel;

    logic [7:0] pixS, pixL;
    logic       validS, validL, sofS, sofL, eolS, eolL, eofS, eofL;
    logic       ovfS, ovfL, doneS, doneL, busyS, busyL;

    logic [7:0] obsPix;
    logic       obsValid, obsSof, obsEol, obsEof, obsOvf, obsDone, obsBusy;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state
    int         mW, mH, mD;
    logic [10:0] mQ[$];
    int         mPos;
    bit         mOvf;
    bit         mDone;

    // Counts of what the DUT actually delivered
    int obsPops, obsSofCnt, obsEolCnt, obsEofCnt, obsDoneCnt;

    conv_out_framer #(.PIXEL_BITS(8), .OUT_W(4), .OUT_H(3), .FIFO_DEPTH(4)) dutS (
        .clk(clk), .rst(rst), .in_pixel(in_pixel), .in_valid(in_valid),
        .out_pixel(pixS), .out_valid(validS), .out_ready(out_ready),
        .out_sof(sofS), .out_eol(eolS), .out_eof(eofS),
        .overflow(ovfS), .frame_done(doneS), .busy(busyS)
    );

    conv_out_framer #(.PIXEL_BITS(8), .OUT_W(126), .OUT_H(126), .FIFO_DEPTH(16)) dutL (
        .clk(clk), .rst(rst), .in_pixel(in_pixel), .in_valid(in_valid),
        .out_pixel(pixL), .out_valid(validL), .out_ready(out_ready),
        .out_sof(sofL), .out_eol(eolL), .out_eof(eofL),
        .overflow(ovfL), .frame_done(doneL), .busy(busyL)
    );

    assign obsPix   = sel ? pixL   : pixS;
    assign obsValid = sel ? validL : validS;
    assign obsSof   = sel ? sofL   : sofS;
    assign obsEol   = sel ? eolL   : eolS;
    assign obsEof   = sel ? eofL   : eofS;
    assign obsOvf   = sel ? ovfL   : ovfS;
    assign obsDone  = sel ? doneL  : doneS;
    assign obsBusy  = sel ? busyL  : busyS;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clearCounts();
        obsPops = 0; obsSofCnt = 0; obsEolCnt = 0; obsEofCnt = 0; obsDoneCnt = 0;
    endtask

    task automatic modelReset();
        mQ.delete();
        mPos  = 0;
        mOvf  = 1'b0;
        mDone = 1'b0;
    endtask

    // One clock of the reference model: frame index drives tags, queue is the buffer
    task automatic modelStep(input bit v, input logic [7:0] d, input bit r);
        logic [10:0] w;
        bit popM, fullM, tSof, tEol, tEof;
        popM  = (mQ.size() > 0) && r;
        fullM = (mQ.size() >= mD);
        mDone = 1'b0;
        if (popM) begin
            w = mQ.pop_front();
            mDone = w[8];
        end
        if (v) begin
            tSof = (mPos == 0);
            tEol = ((mPos % mW) == mW - 1);
            tEof = (mPos == mW * mH - 1);
            if (!fullM || popM) mQ.push_back({tSof, tEol, tEof, d});
            else mOvf = 1'b1;
            mPos = (mPos + 1) % (mW * mH);
        end
    endtask

    task automatic compareAll();
        checkOutput("outValid", 32'(obsValid), 32'(mQ.size() != 0));
        if (mQ.size() != 0)
            checkOutput("outWord", 32'({obsSof, obsEol, obsEof, obsPix}), 32'(mQ[0]));
        checkOutput("overflow", 32'(obsOvf), 32'(mOvf));
        checkOutput("frameDone", 32'(obsDone), 32'(mDone));
        checkOutput("busy", 32'(obsBusy), 32'((mPos != 0) || (mQ.size() != 0)));
        if (obsDone) obsDoneCnt++;
    endtask

    // Drive one cycle from a negedge, step the model at posedge, compare at next negedge
    task automatic applyStimulus(input bit v, input logic [7:0] d, input bit r);
        in_valid  = v;
        in_pixel  = d;
        out_ready = r;
        #1;
        if (obsValid && r) begin
            obsPops++;
            obsSofCnt += int'(obsSof);
            obsEolCnt += int'(obsEol);
            obsEofCnt += int'(obsEof);
        end
        @(posedge clk);
        modelStep(v, d, r);
        @(negedge clk);
        compareAll();
    endtask

    task automatic drain(input int budget);
        for (int c = 0; c < budget && mQ.size() != 0; c++) applyStimulus(1'b0, 8'h00, 1'b1);
    endtask

    task automatic doReset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_pixel = 8'h00;
        @(negedge clk);
        checkOutput("resetOutputs",
                    32'({obsPix, obsValid, obsSof, obsEol, obsEof, obsOvf, obsDone, obsBusy}), 32'(0));
        rst = 1'b0;
        modelReset();
        clearCounts();
    endtask

    initial begin
        int p;
        int cyc;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_pixel = 8'h00; sel = 1'b0;
        mW = 4; mH = 3; mD = 4;
        modelReset();
        clearCounts();
        @(negedge clk);

        $display("[TB] test 1: back-to-back frame, consumer always ready");
        doReset();
        for (int i = 1; i <= 12; i++) applyStimulus(1'b1, 8'(i), 1'b1);
        drain(10);
        checkOutput("t1Pops", obsPops, 12);
        checkOutput("t1Sof", obsSofCnt, 1);
        checkOutput("t1Eol", obsEolCnt, 3);
        checkOutput("t1Done", obsDoneCnt, 1);

        $display("[TB] test 2: stalled consumer causes drops");
        doReset();
        for (int i = 1; i <= 6; i++) applyStimulus(1'b1, 8'(i), 1'b0);
        checkOutput("t2Overflow", 32'(obsOvf), 1);
        drain(10);
        for (int i = 7; i <= 12; i++) applyStimulus(1'b1, 8'(i), 1'b1);
        drain(10);
        checkOutput("t2Pops", obsPops, 10);
        checkOutput("t2Eol", obsEolCnt, 3);
        checkOutput("t2Eof", obsEofCnt, 1);
        checkOutput("t2Done", obsDoneCnt, 1);

        $display("[TB] test 3: push and pop together while full");
        doReset();
        for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 8'(i), 1'b0);
        applyStimulus(1'b1, 8'd5, 1'b1);
        checkOutput("t3NoOverflow", 32'(obsOvf), 0);
        clearCounts();
        drain(10);
        checkOutput("t3Occupancy", obsPops, 4);

        $display("[TB] test 4: sparse input over two frames, toggling ready");
        doReset();
        for (int i = 0; i < 72; i++)
            applyStimulus(i % 3 == 0, 8'($urandom), i % 2 == 0);
        drain(20);
        checkOutput("t4Pops", obsPops, 24);
        checkOutput("t4Sof", obsSofCnt, 2);
        checkOutput("t4Eof", obsEofCnt, 2);
        checkOutput("t4Done", obsDoneCnt, 2);

        $display("[TB] test 5: asynchronous reset mid-frame");
        doReset();
        for (int i = 1; i <= 3; i++) applyStimulus(1'b1, 8'(i), 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        applyStimulus(1'b1, 8'd4, 1'b0);
        applyStimulus(1'b1, 8'd5, 1'b0);
        checkOutput("t5Buffered", 32'(obsValid), 1);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checkOutput("t5AsyncReset",
                    32'({obsPix, obsValid, obsSof, obsEol, obsEof, obsOvf, obsDone, obsBusy}), 32'(0));
        modelReset();
        @(negedge clk);
        rst = 1'b0;
        clearCounts();
        for (int i = 1; i <= 3; i++) applyStimulus(1'b1, 8'(20 + i), 1'b0);
        drain(10);
        checkOutput("t5Sof", obsSofCnt, 1);
        checkOutput("t5Eol", obsEolCnt, 0);
        checkOutput("t5Pops", obsPops, 3);

        $display("[TB] test 6: full 126x126 frame, random ready");
        sel = 1'b1;
        mW = 126; mH = 126; mD = 16;
        doReset();
        p = 0;
        cyc = 0;
        while (p < 15876 && cyc < 60000) begin
            bit v;
            v = ($urandom_range(0, 99) < 60) && (mQ.size() < mD);
            applyStimulus(v, 8'(((p / 126) + (p % 126)) % 256), $urandom_range(0, 99) < 70);
            if (v) p++;
            cyc++;
        end
        checkOutput("t6FeedBudget", p, 15876);
        drain(40);
        checkOutput("t6Pops", obsPops, 15876);
        checkOutput("t6Eof", obsEofCnt, 1);
        checkOutput("t6Eol", obsEolCnt, 126);
        checkOutput("t6Done", obsDoneCnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
